// File: rtl/int_sched_pkg.sv
// Shared types and sizes for the interrupt scheduler: line ids, stack geometry, FSM states.
package int_sched_pkg;

  localparam int unsigned NUM_LINES   = 8;
  localparam int unsigned STACK_DEPTH = 4;

  typedef logic [2:0] line_id_t;

  typedef enum logic [1:0] {
    StIdle,
    StOffer,
    StGap
  } state_e;

endpackage

// File: rtl/int_sched_if.sv
// Bundle between the interrupt scheduler and CP0: raw lines, masks, handshake and status.
interface int_sched_if;

  logic [int_sched_pkg::NUM_LINES-1:0] irq_in;
  logic [int_sched_pkg::NUM_LINES-1:0] im;
  logic                                ie;
  logic                                take;
  logic                                eret;
  logic                                int_req;
  int_sched_pkg::line_id_t             int_id;
  logic [31:0]                         vector;
  logic [int_sched_pkg::NUM_LINES-1:0] in_service;
  logic [2:0]                          depth;

  modport master (
    output irq_in, im, ie, take, eret,
    input  int_req, int_id, vector, in_service, depth
  );

  modport slave (
    input  irq_in, im, ie, take, eret,
    output int_req, int_id, vector, in_service, depth
  );

endinterface

// File: rtl/prio_enc8.sv
// Fixed-priority encoder: lowest set request bit wins.
module prio_enc8 (
  input  logic [7:0] req,
  output logic       valid,
  output logic [2:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    // Walk high to low so the lowest index is written last.
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/int_sched.sv
// Nested vectored interrupt scheduler: edge capture, fixed-priority offer to CP0,
// and a 4-deep in-service stack that only admits strictly higher-priority preemption.
module int_sched #(
  parameter logic [31:0] VEC_BASE  = 32'h0000_0180,
  parameter int unsigned VEC_SHIFT = 5
) (
  input logic       clk,
  input logic       clr,
  int_sched_if.slave bus
);
  import int_sched_pkg::*;

  logic [NUM_LINES-1:0] irq_q, pending_q, pending_d;
  logic [NUM_LINES-1:0] rise, below, eligible, clr_mask, in_service;
  line_id_t             stack_q [STACK_DEPTH];
  line_id_t             stack_d [STACK_DEPTH];
  logic [2:0]           depth_q, depth_d;
  state_e               state_q, state_d;
  line_id_t             id_q, id_d;
  line_id_t             top, win_idx;
  logic                 win_valid, do_push, do_pop, room;

  assign rise = bus.irq_in & ~irq_q;
  // depth=4 wraps the 2-bit index to 3, which is still the correct top slot.
  assign top  = stack_q[depth_q[1:0] - 2'd1];
  assign room = depth_q < 3'(STACK_DEPTH);

  always_comb begin
    below = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      below[i] = (depth_q == 3'd0) || (3'(i) < top);
    end
  end

  assign eligible = pending_q & bus.im & {NUM_LINES{bus.ie}} & below & {NUM_LINES{room}};

  prio_enc8 u_prio (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    do_push = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d = StOffer;
          id_d    = win_idx;
        end
      end
      StOffer: begin
        if (bus.take) begin
          do_push = 1'b1;
          state_d = StGap;
        end else if (!eligible[id_q]) begin
          state_d = StIdle;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign do_pop = bus.eret && (depth_q != 3'd0);

  always_comb begin
    stack_d  = stack_q;
    depth_d  = depth_q;
    clr_mask = '0;
    if (do_push && do_pop) begin
      stack_d[depth_q[1:0] - 2'd1] = id_q;
    end else if (do_push) begin
      stack_d[depth_q[1:0]] = id_q;
      depth_d               = depth_q + 3'd1;
    end else if (do_pop) begin
      depth_d = depth_q - 3'd1;
    end
    if (do_push) clr_mask[id_q] = 1'b1;
    // A fresh edge in the same cycle as the acknowledge must survive the clear.
    pending_d = (pending_q & ~clr_mask) | rise;
  end

  always_comb begin
    in_service = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (3'(i) < depth_q) in_service[stack_q[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= StIdle;
      id_q      <= '0;
      irq_q     <= '0;
      pending_q <= '0;
      depth_q   <= '0;
      stack_q   <= '{default: '0};
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      irq_q     <= bus.irq_in;
      pending_q <= pending_d;
      depth_q   <= depth_d;
      stack_q   <= stack_d;
    end
  end

  assign bus.int_req    = (state_q == StOffer);
  assign bus.int_id     = id_q;
  assign bus.vector     = VEC_BASE + (32'(id_q) << VEC_SHIFT);
  assign bus.in_service = in_service;
  assign bus.depth      = depth_q;

endmodule

// File: doc/int_sched.md
INT_SCHED -- requirements
Module: int_sched

Interface
REQ-001 Parameter VEC_BASE, default 32'h0000_0180, SHALL be the handler address of line 0.
REQ-002 Parameter VEC_SHIFT, default 5, SHALL be log2 of the per-line vector stride in bytes.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 clr  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 irq_in  input  8  SHALL be the raw hardware interrupt lines, level, rising edge significant.
REQ-006 im  input  8  SHALL be the per-line mask from CP0 status (1 = enabled).
REQ-007 ie  input  1  SHALL be the CP0 global interrupt enable.
REQ-008 take  input  1  SHALL be the CP0 acknowledge that the offered interrupt is vectored this cycle.
REQ-009 eret  input  1  SHALL be the return-from-exception strobe.
REQ-010 int_req  output  1  SHALL be the registered interrupt offer to CP0.
REQ-011 int_id  output  3  SHALL be the offered line number, valid while int_req=1.
REQ-012 vector  output  32  SHALL be VEC_BASE + (int_id << VEC_SHIFT).
REQ-013 in_service  output  8  SHALL be the one-hot OR of all lines on the nesting stack.
REQ-014 depth  output  3  SHALL be the nesting stack occupancy, 0..4.

Function
REQ-015 A pending bit SHALL be set on any posedge where irq_in[i]=1 and the previous sampled irq_in[i]=0; repeated edges while pending SHALL NOT accumulate.
REQ-016 Line i SHALL be eligible when pending[i], im[i] and ie are 1, depth<4, and i is numerically lower than the stack top (any line when depth=0).
REQ-017 Priority SHALL be fixed: lowest line index wins.
REQ-018 FSM states: IDLE, OFFER, GAP.
REQ-019 IDLE -> OFFER when any line is eligible: int_req=1 and int_id = winner from the next cycle.
REQ-020 In OFFER, int_id SHALL stay stable; no re-arbitration even if a higher-priority line becomes eligible.
REQ-021 In OFFER, take=1 SHALL push int_id, clear its pending bit, drop int_req next cycle, and go to GAP.
REQ-022 In OFFER, if the offered line stops being eligible and take=0, int_req SHALL drop next cycle and the FSM SHALL return to IDLE.
REQ-023 GAP SHALL last exactly one cycle with int_req=0, then return to IDLE.
REQ-024 eret with depth>0 SHALL pop the stack top; eret with depth=0 SHALL be ignored.
REQ-025 take and eret in the same cycle SHALL pop then push: depth unchanged, top replaced by int_id.
REQ-026 A new rising edge on line i in the cycle take clears pending[i] SHALL leave pending[i]=1.
REQ-027 take while not in OFFER SHALL be ignored.
REQ-028 Latency: first high sample of irq_in at posedge k sets pending at k; int_req visible after posedge k+1.

Reset
REQ-029 clr=1 at posedge SHALL force: state IDLE, pending=0, stack empty, depth=0, in_service=0, int_req=0, int_id=0, vector=VEC_BASE, edge-sample register=0.
REQ-030 clr SHALL override take, eret and edges in the same cycle; reset mid-OFFER SHALL drop int_req next cycle.
REQ-031 A line held high through reset SHALL register one rising edge on the first posedge after clr deasserts.

Structure
REQ-032 Package int_sched_pkg SHALL hold NUM_LINES=8, STACK_DEPTH=4, the state enum and the line-id typedef.
REQ-033 Winner selection SHALL be a sub-module prio_enc8 (8-bit request in, valid and 3-bit index out).

Verification
REQ-034 Reset, then irq_in=8'h04, im=8'hFF, ie=1 -> int_req=1, int_id=2, vector=32'h0000_01C0 two cycles later.
REQ-035 irq_in 8'h30 simultaneous edges, take each offer -> ids 4 then 5; depth stays 1 until eret, since 5 cannot preempt 4.
REQ-036 Line 6 in service, edge on line 1 -> preempt offer id 1; take -> depth=2, in_service=8'h42; eret twice -> depth=0.
REQ-037 Four nested takes on lines 7,5,3,1, then edge on line 0 -> no int_req until eret brings depth to 3.
REQ-038 Offer id 3 pending, clear im[3] before take -> int_req drops next cycle, pending[3] retained, re-offered when im[3]=1.
REQ-039 take and eret same cycle at depth 2 -> depth stays 2; clr during OFFER -> all outputs at reset values.
